nibble_deserializer: RTL and testbench
======================================

# nibble_deserializer

Serial-in, parallel-out front end that assembles a 1-bit input stream into 4-bit words and presents each completed word on a valid/ready interface. It sits directly upstream of the 4-bit storage register: `dout` drives the register's `D`, and `dout_valid & dout_ready` is the load condition. A one-word output holding buffer lets the block accept the next word's bits while the current word waits. Backpressure reaches the serial side only when both the shifter and the buffer are full.

## Interface
- `LSB_FIRST`, default 1: 1 = first accepted bit lands in `dout[0]`; 0 = first accepted bit lands in `dout[3]`.
- `clk` input 1: single clock, rising edge.
- `clr_n` input 1: asynchronous, active-low reset.
- `sin` input 1: serial data bit.
- `sin_valid` input 1: `sin` carries a bit this cycle.
- `sin_ready` output 1: block can take a bit this cycle.
- `flush` input 1: synchronous discard of a partial word.
- `dout` output 4: assembled word, stable while `dout_valid` is high.
- `dout_valid` output 1: holding buffer contains a word.
- `dout_ready` input 1: downstream accepts the word this cycle.
- `busy` output 1: partial word in progress (`bit_cnt != 0`).

## Operation
- **State.**
  - `shreg[3:0]` shift register.
  - `bit_cnt[1:0]`.
  - Holding buffer `hold[3:0]` plus `hold_v`.
  - Two-state FSM over `bit_cnt`: IDLE (`cnt == 0`) and SHIFT (`cnt` 1..3).
- **Bit accept.** A bit is accepted when `sin_valid & sin_ready`.
  - `LSB_FIRST = 1`: the bit is written to `shreg[bit_cnt]`.
  - `LSB_FIRST = 0`: the bit is written to `shreg[3 - bit_cnt]`.
  - `bit_cnt` increments and wraps 3 → 0.
- **Word complete.** The accepted bit is the fourth one (`bit_cnt == 3`).
  - The full word (`shreg` with the new bit merged) is written to `hold`, and `hold_v` is set.
  - `bit_cnt` returns to 0. The FSM goes SHIFT → IDLE.
- **Drain.** When `dout_valid & dout_ready`, `hold_v` clears, unless a word completes in the same cycle.
- **Simultaneous drain and complete.** The new word overwrites `hold`, `hold_v` stays 1, and no word is lost.
- **`sin_ready`.**
  - Low when `bit_cnt == 3 & hold_v & ~dout_ready`; high otherwise.
  - Combinational from `dout_ready`. No path exists from `sin_valid` to `sin_ready`.
- **`flush`.**
  - Sets `bit_cnt` to 0 and clears `shreg`. `hold` and `hold_v` are unaffected.
  - A bit presented in a flush cycle is not accepted; `sin_ready` is forced low while `flush` is high.
- **Outputs.**
  - `dout` = `hold`.
  - `dout_valid` = `hold_v`.
  - `busy` = (`bit_cnt != 0`).

## Timing
- **Reset.** `clr_n` low asynchronously clears `shreg`, `bit_cnt`, `hold` and `hold_v`.
  - `dout` = 0, `dout_valid` = 0, `busy` = 0.
  - `sin_ready` = 1 while in reset, since the terms forcing it low are cleared (it is combinational).
- **Reset release.** Release is synchronous to `clk` at the system level. The first bit can be accepted on the first rising edge after `clr_n` goes high.
- **Reset mid-word.** The partial word and any buffered word are lost. No `dout_valid` pulse appears for them.
- **Latency.** The fourth bit accepted at edge k gives `dout_valid` = 1 and `dout` = word after edge k, i.e. visible in cycle k+1.
- **Throughput.** One word per 4 accepted bits. With `dout_ready` held high, `sin_ready` never deasserts.
- **Full stall.** Buffer full, three bits pending, `dout_ready` = 0.
  - `sin_ready` = 0, and the fourth bit is held off indefinitely.
  - The cycle `dout_ready` rises, `sin_ready` rises combinationally. The bit is accepted and the buffer is refilled on that edge.
- **Gaps.** `sin_valid` gaps of any length are allowed; state holds.
- **Flush timing.** Takes effect on the next edge. Simultaneous `flush` and `clr_n` low: reset wins.

## Test plan
- **Basic assemble.** `LSB_FIRST = 1`, bits 1,0,1,1 on consecutive cycles, `dout_ready` = 1 → `dout` = 4'hD, `dout_valid` high for exactly 1 cycle, in the cycle after the 4th bit.
- **MSB-first.** `LSB_FIRST = 0`, same bits 1,0,1,1 → `dout` = 4'hB.
- **Backpressure.** `dout_ready` = 0; stream 0xA then the first 3 bits of 0x5 → `dout` holds 4'hA and `sin_ready` = 0 with the 4th bit offered. Raise `dout_ready` for 1 cycle → 0xA consumed, 0x5 loaded next cycle, no bit dropped.
- **Simultaneous drain and complete.** `dout_valid` high with 0x3; the 4th bit of 0xC arrives in the same cycle `dout_ready` = 1 → `dout_valid` stays high, `dout` changes 3 → C.
- **Flush.** Send 2 bits, pulse `flush`, then send 1,1,1,1 → `busy` = 0 after the flush, and the next word is 4'hF with no remnant.
- **Async reset.** Assert `clr_n` low between clock edges with 2 bits pending and a buffered word → `dout`, `dout_valid` and `busy` go to 0 immediately (without a clock edge); after release, 0x6 assembles correctly.

Source files
------------

// File: rtl/nibble_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_deserializer_if
//  Description : Bus bundle for the nibble deserializer. It carries the serial
//                input side (sin / sin_valid / sin_ready / flush) and the
//                word-output side (dout / dout_valid / dout_ready / busy).
//                The slave modport is the deserializer's view of the bus.
//                The master modport is the view of whatever drives the
//                serial bits and consumes the words.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nibble_deserializer_if;
    logic       sin;
    logic       sin_valid;
    logic       sin_ready;
    logic       flush;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;

    modport master (
        output sin, sin_valid, flush, dout_ready,
        input  sin_ready, dout, dout_valid, busy
    );

    modport slave (
        input  sin, sin_valid, flush, dout_ready,
        output sin_ready, dout, dout_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/nibble_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_deserializer
//  Description : Assembles a 1-bit serial stream into 4-bit words. Each
//                completed word is presented through a one-word holding
//                buffer on a valid/ready interface. The serial side is
//                stalled only when the shifter holds three bits, the buffer
//                is full and downstream is not taking the buffered word.
//  Ports       : clk   - rising-edge clock
//                clr_n - asynchronous active-low reset
//                bus   - slave modport carrying:
//                        sin, sin_valid, sin_ready, flush   (serial side)
//                        dout, dout_valid, dout_ready, busy (word side)
//  Parameters  : LSB_FIRST - 1: first bit lands in dout[0]
//                            0: first bit lands in dout[3]
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_deserializer #(
    parameter int LSB_FIRST = 1
) (
    input  wire logic              clk,
    input  wire logic              clr_n,
    nibble_deserializer_if.slave   bus
);

    // IDLE <=> bit_cnt == 0, SHIFT <=> bit_cnt in 1..3
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t     state_q,   state_d;
    logic [1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] shreg_q,   shreg_d;
    logic [3:0] hold_q,    hold_d;
    logic       hold_v_q,  hold_v_d;

    logic       w_last;
    logic       w_stall;
    logic       w_sin_ready;
    logic       w_accept;
    logic       w_complete;
    logic       w_drain;
    logic [1:0] w_bit_idx;
    logic [3:0] w_merged;

    assign w_last      = (bit_cnt_q == 2'd3);
    // Only the fourth bit needs the buffer, and the buffer frees up in the
    // same cycle downstream takes it, so dout_ready may release the stall.
    assign w_stall     = w_last & hold_v_q & ~bus.dout_ready;
    assign w_sin_ready = ~bus.flush & ~w_stall;
    assign w_accept    = bus.sin_valid & w_sin_ready;
    assign w_complete  = w_accept & w_last;
    assign w_drain     = hold_v_q & bus.dout_ready;

    // MSB-first position is 3 - bit_cnt, which is the bitwise inverse for 2 bits
    assign w_bit_idx   = (LSB_FIRST != 0) ? bit_cnt_q : ~bit_cnt_q;

    // Shift register contents with the incoming bit already merged, so the
    // fourth bit can go straight into the holding buffer.
    always_comb begin
        w_merged            = shreg_q;
        w_merged[w_bit_idx] = bus.sin;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;

        if (bus.flush) begin
            // sin_ready is low during flush, so no bit can be accepted here
            state_d   = ST_IDLE;
            bit_cnt_d = 2'd0;
            shreg_d   = 4'd0;
        end else if (w_accept) begin
            if (w_last) begin
                state_d   = ST_IDLE;
                bit_cnt_d = 2'd0;
                shreg_d   = 4'd0;
                hold_d    = w_merged;
            end else begin
                state_d   = ST_SHIFT;
                bit_cnt_d = bit_cnt_q + 2'd1;
                shreg_d   = w_merged;
            end
        end

        // A completing word takes priority over the drain, so a word that
        // lands in the same cycle the old one leaves keeps the buffer valid.
        if (w_complete) begin
            hold_v_d = 1'b1;
        end else if (w_drain) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 2'd0;
            shreg_q   <= 4'd0;
            hold_q    <= 4'd0;
            hold_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
        end
    end

    assign bus.sin_ready  = w_sin_ready;
    assign bus.dout       = hold_q;
    assign bus.dout_valid = hold_v_q;
    assign bus.busy       = (state_q == ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_nibble_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_deserializer
//  Description : Self-checking bench. An LSB-first and an MSB-first instance
//                receive identical stimulus. A queue-based reference model
//                tracks pending bits and the buffered word for both bit
//                orders. Directed scenarios are followed by a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_deserializer;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    nibble_deserializer_if ifa ();
    nibble_deserializer_if ifb ();

    nibble_deserializer #(.LSB_FIRST(1)) u_lsb (.clk(clk), .clr_n(clr_n), .bus(ifa));
    nibble_deserializer #(.LSB_FIRST(0)) u_msb (.clk(clk), .clr_n(clr_n), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending bits in arrival order plus the buffered word
    bit       mq[$];
    bit [3:0] m_hold_a;     // buffered word, LSB-first interpretation
    bit [3:0] m_hold_b;     // buffered word, MSB-first interpretation
    bit       m_hv;

    bit cur_s, cur_sv, cur_fl, cur_dr;

    function automatic bit m_ready(input bit fl, input bit dr);
        return !fl && !(mq.size() == 3 && m_hv && !dr);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_hold_a = 4'd0;
        m_hold_b = 4'd0;
        m_hv     = 1'b0;
    endtask

    // Apply inputs to both instances and let combinational outputs settle
    task automatic set_in(input bit s, input bit sv, input bit fl, input bit dr);
        cur_s = s; cur_sv = sv; cur_fl = fl; cur_dr = dr;
        ifa.sin = s; ifa.sin_valid = sv; ifa.flush = fl; ifa.dout_ready = dr;
        ifb.sin = s; ifb.sin_valid = sv; ifb.flush = fl; ifb.dout_ready = dr;
        #1;
    endtask

    // Advance one clock edge and update the model with the current inputs
    task automatic tick();
        bit acc, drain, done;
        bit [3:0] wa, wb;
        acc   = cur_sv && m_ready(cur_fl, cur_dr);
        drain = m_hv && cur_dr;
        done  = 1'b0;
        @(posedge clk);
        if (cur_fl) begin
            mq.delete();
        end else if (acc) begin
            mq.push_back(cur_s);
            if (mq.size() == 4) begin
                wa = 4'd0;
                wb = 4'd0;
                for (int i = 0; i < 4; i++) begin
                    wa = wa | (4'(mq[i]) << i);
                    wb = wb | (4'(mq[i]) << (3 - i));
                end
                m_hold_a = wa;
                m_hold_b = wb;
                mq.delete();
                done = 1'b1;
            end
        end
        if (done)       m_hv = 1'b1;
        else if (drain) m_hv = 1'b0;
        #1;
    endtask

    // Send a word LSB-first-in-time: bit i of w goes out i-th
    task automatic send_word(input bit [3:0] w, input int nbits, input bit dr);
        for (int i = 0; i < nbits; i++) begin
            set_in(w[i], 1'b1, 1'b0, dr);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, dr);
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        model_reset();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        n_checks++;
        if (ifa.dout !== 4'h0 || ifa.dout_valid !== 1'b0 || ifa.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dout=%h dv=%b busy=%b expected 0/0/0",
                     ifa.dout, ifa.dout_valid, ifa.busy);
        end
        n_checks++;
        if (ifa.sin_ready !== 1'b1 || ifb.sin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sin_ready: got %b/%b expected 1/1", ifa.sin_ready, ifb.sin_ready);
        end
        @(posedge clk);
        #1;
        clr_n = 1'b1;
    endtask

    task automatic test_basic();
        bit [3:0] w = 4'b1101;    // bits 1,0,1,1 in arrival order
        for (int i = 0; i < 4; i++) begin
            set_in(w[i], 1'b1, 1'b0, 1'b1);
            tick();
            if (i < 3) begin
                n_checks++;
                if (ifa.dout_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_early_valid: bit %0d got dv=%b expected 0", i, ifa.dout_valid);
                end
            end
        end
        n_checks++;
        if (ifa.dout_valid !== 1'b1 || ifa.dout !== 4'hD) begin
            n_fail++;
            $display("FAIL basic_lsb: got dv=%b dout=%h expected 1/D", ifa.dout_valid, ifa.dout);
        end
        n_checks++;
        if (ifb.dout_valid !== 1'b1 || ifb.dout !== 4'hB) begin
            n_fail++;
            $display("FAIL basic_msb: got dv=%b dout=%h expected 1/B", ifb.dout_valid, ifb.dout);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (ifa.dout_valid !== 1'b0 || ifb.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle: got dv=%b/%b expected 0/0", ifa.dout_valid, ifb.dout_valid);
        end
    endtask

    task automatic test_backpressure();
        send_word(4'hA, 4, 1'b0);
        send_word(4'h5, 3, 1'b0);
        set_in(1'b0, 1'b1, 1'b0, 1'b0);   // 4th bit of 0x5 offered
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ifa.sin_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall: cycle %0d got sin_ready=%b expected 0", i, ifa.sin_ready);
            end
            tick();
            n_checks++;
            if (ifa.dout !== 4'hA || ifa.dout_valid !== 1'b1 || ifa.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold: got dout=%h dv=%b busy=%b expected A/1/1",
                         ifa.dout, ifa.dout_valid, ifa.busy);
            end
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (ifa.sin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got sin_ready=%b expected 1", ifa.sin_ready);
        end
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ifa.dout !== 4'h5 || ifa.dout_valid !== 1'b1 || ifa.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_refill: got dout=%h dv=%b busy=%b expected 5/1/0",
                     ifa.dout, ifa.dout_valid, ifa.busy);
        end
        n_checks++;
        if (ifb.dout !== 4'hA) begin
            n_fail++;
            $display("FAIL bp_refill_msb: got dout=%h expected A", ifb.dout);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (ifa.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got dv=%b expected 0", ifa.dout_valid);
        end
    endtask

    task automatic test_simul_drain();
        send_word(4'h3, 4, 1'b0);
        send_word(4'hC, 3, 1'b0);
        n_checks++;
        if (ifa.dout !== 4'h3 || ifa.dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_pre: got dout=%h dv=%b expected 3/1", ifa.dout, ifa.dout_valid);
        end
        set_in(1'b1, 1'b1, 1'b0, 1'b1);   // 4th bit of 0xC with drain
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ifa.dout !== 4'hC || ifa.dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_post: got dout=%h dv=%b expected C/1", ifa.dout, ifa.dout_valid);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_flush();
        send_word(4'b0001, 2, 1'b1);
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (ifa.sin_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got sin_ready=%b expected 0", ifa.sin_ready);
        end
        tick();
        n_checks++;
        if (ifa.busy !== 1'b0 || ifa.dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got busy=%b dv=%b expected 0/0", ifa.busy, ifa.dout_valid);
        end
        send_word(4'hF, 4, 1'b1);
        n_checks++;
        if (ifa.dout !== 4'hF || ifb.dout !== 4'hF || ifa.dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_word: got dout=%h/%h dv=%b expected F/F/1",
                     ifa.dout, ifb.dout, ifa.dout_valid);
        end
        tick();
    endtask

    task automatic test_async_reset();
        send_word(4'h9, 4, 1'b0);
        send_word(4'h3, 2, 1'b0);
        clr_n = 1'b0;                      // between edges
        model_reset();
        #1;
        n_checks++;
        if (ifa.dout !== 4'h0 || ifa.dout_valid !== 1'b0 || ifa.busy !== 1'b0 ||
            ifb.dout !== 4'h0 || ifb.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got dout=%h dv=%b busy=%b expected 0/0/0",
                     ifa.dout, ifa.dout_valid, ifa.busy);
        end
        n_checks++;
        if (ifa.sin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_ready: got sin_ready=%b expected 1", ifa.sin_ready);
        end
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        send_word(4'h6, 4, 1'b1);
        n_checks++;
        if (ifa.dout !== 4'h6 || ifb.dout !== 4'h6 || ifa.dout_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL async_after: got dout=%h/%h dv=%b expected 6/6/1",
                     ifa.dout, ifb.dout, ifa.dout_valid);
        end
        tick();
    endtask

    task automatic test_random();
        bit s, sv, fl, dr, exp_rdy;
        for (int c = 0; c < 400; c++) begin
            s  = 1'($urandom_range(0, 1));
            sv = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 19) == 0);
            dr = ($urandom_range(0, 4) < 3);
            set_in(s, sv, fl, dr);
            exp_rdy = m_ready(fl, dr);
            n_checks++;
            if (ifa.sin_ready !== exp_rdy || ifb.sin_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_ready: cycle %0d got %b/%b expected %b",
                         c, ifa.sin_ready, ifb.sin_ready, exp_rdy);
            end
            tick();
            n_checks++;
            if (ifa.dout_valid !== m_hv || ifb.dout_valid !== m_hv ||
                ifa.busy !== (mq.size() != 0) || ifb.busy !== (mq.size() != 0) ||
                ifa.dout !== m_hold_a || ifb.dout !== m_hold_b) begin
                n_fail++;
                $display("FAIL rand_out: cycle %0d got dv=%b busy=%b dout=%h/%h expected %b/%b/%h/%h",
                         c, ifa.dout_valid, ifa.busy, ifa.dout, ifb.dout,
                         m_hv, (mq.size() != 0), m_hold_a, m_hold_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_simul_drain();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
